// File: rtl/run_mode_controller.sv
`default_nettype none
// ============================================================================
// Module      : run_mode_controller
// Description : JPEG-LS run-mode sequencer (RUNcnt/RUNindex, J table, run-length
//               bits, interruption remainder). Optional macro RUN_STATS_EN adds
//               the run_total event counter output.
// Revision    : 1.0 - initial release
// ============================================================================
module run_mode_controller #(
    parameter int MODE_LENGTH  = 2,
    parameter int CNT_LENGTH   = 16,
    parameter int INDEX_LENGTH = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    frame_start,
    input  logic [MODE_LENGTH-1:0]  mode,
    input  logic                    mode_valid,
    output logic                    mode_ready,
    output logic                    bit_out,
    output logic                    bit_valid,
    input  logic                    bit_ready,
    output logic                    ri_valid,
    output logic [3:0]              ri_j,
    output logic [INDEX_LENGTH-1:0] run_index,
    output logic                    err
`ifdef RUN_STATS_EN
    ,
    output logic [15:0]             run_total
`endif
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        REM  = 1'b1
    } state_t;

    localparam logic [3:0] c_j_table [0:31] = '{
        4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd1,
        4'd2, 4'd2, 4'd2, 4'd2, 4'd3, 4'd3, 4'd3, 4'd3,
        4'd4, 4'd4, 4'd5, 4'd5, 4'd6, 4'd6, 4'd7, 4'd7,
        4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15
    };

    state_t                  r_state, w_state_nxt;
    logic [CNT_LENGTH-1:0]   r_run_cnt, w_run_cnt_nxt;
    logic [INDEX_LENGTH-1:0] r_run_index, w_run_index_nxt;
    logic [14:0]             r_remainder, w_remainder_nxt;
    logic [3:0]              r_bit_cnt, w_bit_cnt_nxt;
    logic [3:0]              r_ri_j, w_ri_j_nxt;
    logic                    r_ri_valid, w_ri_valid_nxt;
    logic                    r_err, w_err_nxt;

    logic [3:0]              w_j;
    logic [CNT_LENGTH-1:0]   w_n;
    logic                    w_hit;
    logic                    w_accept;
    logic [INDEX_LENGTH-1:0] w_index_inc;
    logic [INDEX_LENGTH-1:0] w_index_dec;
    logic [3:0]              w_bit_sel;

    assign w_j         = c_j_table[r_run_index];
    assign w_n         = r_run_cnt + CNT_LENGTH'(1);
    assign w_hit       = (w_n == (CNT_LENGTH'(1) << w_j));
    assign w_accept    = mode_valid && mode_ready;
    assign w_index_inc = (r_run_index == '1) ? r_run_index : r_run_index + INDEX_LENGTH'(1);
    assign w_index_dec = (r_run_index == '0) ? r_run_index : r_run_index - INDEX_LENGTH'(1);
    assign w_bit_sel   = r_bit_cnt - 4'd1;

    always_comb begin
        w_state_nxt     = r_state;
        w_run_cnt_nxt   = r_run_cnt;
        w_run_index_nxt = r_run_index;
        w_remainder_nxt = r_remainder;
        w_bit_cnt_nxt   = r_bit_cnt;
        w_ri_j_nxt      = r_ri_j;
        w_ri_valid_nxt  = 1'b0;
        w_err_nxt       = r_err;
        mode_ready      = (r_state == IDLE) && bit_ready && !frame_start && !reset;
        bit_valid       = 1'b0;
        bit_out         = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    case (mode)
                        MODE_LENGTH'(0): begin
                            if (r_run_cnt != '0) begin
                                w_err_nxt     = 1'b1;
                                w_run_cnt_nxt = '0;
                            end
                        end
                        MODE_LENGTH'(1): begin
                            if (w_hit) begin
                                bit_valid       = 1'b1;
                                bit_out         = 1'b1;
                                w_run_cnt_nxt   = '0;
                                w_run_index_nxt = w_index_inc;
                            end else begin
                                w_run_cnt_nxt   = w_n;
                            end
                        end
                        MODE_LENGTH'(2): begin
                            bit_valid       = 1'b1;
                            bit_out         = 1'b0;
                            w_ri_j_nxt      = w_j;
                            w_remainder_nxt = r_run_cnt[14:0];
                            w_run_cnt_nxt   = '0;
                            w_run_index_nxt = w_index_dec;
                            if (w_j == 4'd0) begin
                                w_ri_valid_nxt = 1'b1;
                            end else begin
                                w_state_nxt   = REM;
                                w_bit_cnt_nxt = w_j;
                            end
                        end
                        default: begin
                            // EOL always closes the partial run with a single '1'
                            bit_valid     = 1'b1;
                            bit_out       = 1'b1;
                            w_run_cnt_nxt = '0;
                            if (w_hit) begin
                                w_run_index_nxt = w_index_inc;
                            end
                        end
                    endcase
                end
            end
            REM: begin
                bit_valid = 1'b1;
                bit_out   = r_remainder[w_bit_sel];
                if (bit_ready) begin
                    w_bit_cnt_nxt = w_bit_sel;
                    if (r_bit_cnt == 4'd1) begin
                        w_state_nxt    = IDLE;
                        w_ri_valid_nxt = 1'b1;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        if (frame_start) begin
            w_state_nxt     = IDLE;
            w_run_cnt_nxt   = '0;
            w_run_index_nxt = '0;
            w_ri_valid_nxt  = 1'b0;
        end

        if (reset) begin
            bit_valid = 1'b0;
            bit_out   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_run_cnt   <= '0;
            r_run_index <= '0;
            r_remainder <= '0;
            r_bit_cnt   <= '0;
            r_ri_j      <= '0;
            r_ri_valid  <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_run_cnt   <= w_run_cnt_nxt;
            r_run_index <= w_run_index_nxt;
            r_remainder <= w_remainder_nxt;
            r_bit_cnt   <= w_bit_cnt_nxt;
            r_ri_j      <= w_ri_j_nxt;
            r_ri_valid  <= w_ri_valid_nxt;
            r_err       <= w_err_nxt;
        end
    end

    assign ri_valid  = r_ri_valid;
    assign ri_j      = r_ri_j;
    assign run_index = r_run_index;
    assign err       = r_err;

`ifdef RUN_STATS_EN
    logic [15:0] r_run_total;

    always_ff @(posedge clk) begin
        if (reset || frame_start) begin
            r_run_total <= '0;
        end else if (w_accept && (r_state == IDLE) && mode[1] && (r_run_total != 16'hFFFF)) begin
            r_run_total <= r_run_total + 16'd1;
        end
    end

    assign run_total = r_run_total;
`endif

endmodule
`default_nettype wire

// File: tb/tb_run_mode_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_run_mode_controller
// Description : Directed self-checking bench for run_mode_controller.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_run_mode_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic       frame_start;
    logic [1:0] mode;
    logic       mode_valid;
    logic       mode_ready;
    logic       bit_out;
    logic       bit_valid;
    logic       bit_ready;
    logic       ri_valid;
    logic [3:0] ri_j;
    logic [4:0] run_index;
    logic       err;
`ifdef RUN_STATS_EN
    logic [15:0] run_total;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    run_mode_controller dut (
        .clk         (clk),
        .reset       (reset),
        .frame_start (frame_start),
        .mode        (mode),
        .mode_valid  (mode_valid),
        .mode_ready  (mode_ready),
        .bit_out     (bit_out),
        .bit_valid   (bit_valid),
        .bit_ready   (bit_ready),
        .ri_valid    (ri_valid),
        .ri_j        (ri_j),
        .run_index   (run_index),
        .err         (err)
`ifdef RUN_STATS_EN
        ,
        .run_total   (run_total)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after a rising edge; checks land 2 units later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic acc(input logic [1:0] m, input logic ebv, input logic ebo, input string tag);
        mode       = m;
        mode_valid = 1'b1;
        bit_ready  = 1'b1;
        #2;
        chk({tag, "_rdy"}, mode_ready, 1);
        chk({tag, "_bv"}, bit_valid, ebv);
        if (ebv) chk({tag, "_bo"}, bit_out, ebo);
        tick();
        mode_valid = 1'b0;
    endtask

    task automatic acc_q(input logic [1:0] m);
        mode       = m;
        mode_valid = 1'b1;
        bit_ready  = 1'b1;
        tick();
        mode_valid = 1'b0;
    endtask

    task automatic fstart();
        frame_start = 1'b1;
        mode_valid  = 1'b0;
        bit_ready   = 1'b1;
        #2;
        chk("fs_mode_ready", mode_ready, 0);
        tick();
        frame_start = 1'b0;
    endtask

    initial begin
        logic [11:0] e_bits;
        reset       = 1'b1;
        frame_start = 1'b0;
        mode        = 2'd0;
        mode_valid  = 1'b0;
        bit_ready   = 1'b1;
        tick();
        tick();

        // reset state
        mode_valid = 1'b1;
        mode       = 2'd1;
        #2;
        chk("rst_mode_ready", mode_ready, 0);
        chk("rst_bit_valid", bit_valid, 0);
        tick();
        reset      = 1'b0;
        mode_valid = 1'b0;
        #2;
        chk("rst_run_index", run_index, 0);
        chk("rst_err", err, 0);
        chk("rst_ri_valid", ri_valid, 0);
        chk("rst_ri_j", ri_j, 0);
        chk("rst_bit_out", bit_out, 0);
        tick();

        // five run pixels then interruption at idx0: bits 1,1,1,1,0,1
        fstart();
        acc(2'd1, 1'b1, 1'b1, "t1a");
        acc(2'd1, 1'b1, 1'b1, "t1b");
        acc(2'd1, 1'b1, 1'b1, "t1c");
        acc(2'd1, 1'b1, 1'b1, "t1d");
        acc(2'd1, 1'b0, 1'b0, "t1e");
        acc(2'd2, 1'b1, 1'b0, "t1ri");
        bit_ready = 1'b1;
        #2;
        chk("t1_rem_bv", bit_valid, 1);
        chk("t1_rem_bo", bit_out, 1);
        chk("t1_rem_mr", mode_ready, 0);
        chk("t1_ri_j", ri_j, 1);
        chk("t1_ri_early", ri_valid, 0);
        tick();
        chk("t1_ri_pulse", ri_valid, 1);
        chk("t1_run_index", run_index, 3);
        tick();
        chk("t1_ri_drop", ri_valid, 0);

        // single EOL at idx0
        fstart();
        acc(2'd3, 1'b1, 1'b1, "t2");
        chk("t2_run_index", run_index, 1);
        acc(2'd0, 1'b0, 1'b0, "t2m0");
        chk("t2_err_clear", err, 0);

        // idx8: run then EOL, only EOL emits
        fstart();
        repeat (12) acc_q(2'd1);
        chk("t3_idx8", run_index, 8);
        acc(2'd1, 1'b0, 1'b0, "t3a");
        acc(2'd3, 1'b1, 1'b1, "t3b");
        chk("t3_run_index", run_index, 8);

        // idx4: run then EOL hits 2^1
        fstart();
        repeat (4) acc_q(2'd1);
        chk("t4_idx4", run_index, 4);
        acc(2'd1, 1'b0, 1'b0, "t4a");
        acc(2'd3, 1'b1, 1'b1, "t4b");
        chk("t4_run_index", run_index, 5);

        // idx28 (J=12), RUNcnt=5, interruption with stalls
        fstart();
        repeat (4380) acc_q(2'd1);
        chk("t5_idx28", run_index, 28);
        repeat (5) acc(2'd1, 1'b0, 1'b0, "t5run");
        acc(2'd2, 1'b1, 1'b0, "t5ri");
        chk("t5_ri_j", ri_j, 12);
        e_bits = 12'b0000_0000_0101;
        for (int i = 11; i >= 0; i--) begin
            bit_ready = 1'b0;
            #2;
            chk("t5_stall_bv", bit_valid, 1);
            chk("t5_stall_bo", bit_out, e_bits[i]);
            tick();
            bit_ready = 1'b1;
            #2;
            chk("t5_hs_bv", bit_valid, 1);
            chk("t5_hs_bo", bit_out, e_bits[i]);
            chk("t5_hs_mr", mode_ready, 0);
            chk("t5_hs_ri", ri_valid, 0);
            tick();
        end
        chk("t5_ri_pulse", ri_valid, 1);
        chk("t5_run_index", run_index, 27);
        tick();
        chk("t5_ri_drop", ri_valid, 0);

        // reset in the middle of a remainder
        acc(2'd2, 1'b1, 1'b0, "t6ri");
        bit_ready = 1'b1;
        tick();
        reset = 1'b1;
        #2;
        chk("t6_rst_bv", bit_valid, 0);
        tick();
        reset = 1'b0;
        #2;
        chk("t6_bv", bit_valid, 0);
        chk("t6_run_index", run_index, 0);
        chk("t6_ri", ri_valid, 0);
        tick();
        chk("t6_ri_after", ri_valid, 0);

        // J==0 interruption: ri_valid next cycle, stays IDLE
        acc(2'd2, 1'b1, 1'b0, "t8ri");
        bit_ready = 1'b1;
        #2;
        chk("t8_ri_pulse", ri_valid, 1);
        chk("t8_ri_j", ri_j, 0);
        chk("t8_mr", mode_ready, 1);
        chk("t8_bv", bit_valid, 0);
        tick();
        chk("t8_ri_drop", ri_valid, 0);

        // regular pixel while a run is pending
        fstart();
        repeat (12) acc_q(2'd1);
        repeat (3) acc(2'd1, 1'b0, 1'b0, "t7run");
        acc(2'd0, 1'b0, 1'b0, "t7m0");
        chk("t7_err", err, 1);
        acc(2'd1, 1'b0, 1'b0, "t7post");
        fstart();
        chk("t7_err_sticky", err, 1);
        chk("t7_idx_fs", run_index, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
